seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across DIGITS common-cathode digit positions.
- Drives the decoder's digit code and its active-low controls: LE (0 = transparent, 1 = hold), BL (0 = blank) and LT (0 = all segments on).
- Also drives a one-hot digit-select bus.
- Provides the power-on lamp test, frame-synchronous value updates, leading-zero blanking and anti-ghosting guard blanking.
- Sits between the datapath that produces BCD values and the decoder/digit drivers.

Parameters:
- DIGITS, 4, number of digit positions (2..8); digit 0 is least significant.
- DIV, 16, clocks per digit slot (>= 2).
- BLANK_CYC, 1, guard clocks at the start of each slot (0 .. DIV-1).
- LT_FRAMES, 2, full scan frames spent in lamp test (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture bcd_in.
- bcd_in  in  4*DIGITS  digit i at bits [4i+3:4i].
- lzb_en  in  1  leading-zero blanking enable.
- disp_en  in  1  display enable (level).
- lamp_test_req  in  1  single-cycle strobe; start a lamp test.
- dec_d  out  4  BCD code to the decoder.
- dec_le  out  1  decoder latch enable.
- dec_bl  out  1  decoder blank, active-low.
- dec_lt  out  1  decoder lamp test, active-low.
- dig_sel  out  DIGITS  one-hot digit enable, active-high.
- busy  out  1  lamp test in progress.

Behaviour:
- Interface: one clock clk; rst_n is asynchronous and active-low.
- Reset values: state = LAMP, cnt = 0, idx = 0, frame counter = 0, hold register = 0, display register = 0, pending = 0.
- Output reset values: dig_sel = 0, dec_d = 0, dec_le = 0, dec_bl = 0, dec_lt = 1, busy = 1.
- Every output is registered and reflects the state/cnt/idx of the previous cycle (1-clock latency).
- Scan timing:
  - cnt runs 0..DIV-1. When cnt = DIV-1, cnt wraps to 0 and idx advances, wrapping from DIGITS-1 to 0.
  - Frame boundary: the cycle in which cnt = DIV-1 and idx = DIGITS-1.
- Guard: while cnt < BLANK_CYC, dig_sel = 0 and dec_bl = 0, in every state.
- Outside the guard, dig_sel = one-hot(idx).
- dec_le is always 0; the controller never uses decoder hold.
- State LAMP:
  - dec_lt = 0, dec_bl = 1 (outside guard), dec_d = 0, busy = 1.
  - Leave after LT_FRAMES frame boundaries: go to RUN if disp_en = 1, else OFF.
- State RUN:
  - dec_lt = 1 and dec_d = display digit[idx].
  - dec_bl = 0 if the digit is leading-zero blanked, else 1 (outside guard).
- State OFF:
  - dig_sel = 0, dec_bl = 0, dec_lt = 1; cnt and idx are held at 0.
- Transitions:
  - RUN with disp_en = 0 goes to OFF on the next clock.
  - OFF with disp_en = 1 goes to RUN with cnt = 0 and idx = 0.
- Lamp test request: lamp_test_req in RUN or OFF goes to LAMP on the next clock, with cnt, idx and frame counter cleared.
  - lamp_test_req during LAMP is ignored; the count is not extended.
  - lamp_test_req has priority over disp_en.
- Load path:
  - load copies bcd_in into the hold register and sets pending.
  - At each frame boundary in RUN or LAMP with pending = 1: hold is copied to display and pending is cleared. A frame never shows mixed old/new digits.
  - If load coincides with the frame boundary, display takes bcd_in directly and pending stays 0.
  - In OFF, a pending value is transferred on the OFF-to-RUN transition.
- Leading-zero blanking (lzb_en = 1): digit i is blanked iff every display digit from DIGITS-1 down to i equals 0. Digit 0 is never blanked.
- Digit codes 10..15 are passed to dec_d unchanged; the decoder blanks them itself. For leading-zero blanking they count as nonzero.
- Asynchronous reset at any point forces the reset values immediately and restarts the lamp test.

Test Plan:
Bench parameters: DIGITS = 4, DIV = 4, BLANK_CYC = 1, LT_FRAMES = 1.
- Release rst_n with disp_en = 1:
  - busy = 1 and dec_lt = 0 for 16 clocks.
  - dig_sel pattern per slot: 0000 for 1 clock, then 0001 for 3 clocks; likewise 0010, 0100, 1000.
  - Then busy = 0, dec_lt = 1.
- In RUN, load with bcd_in = 16'h1234 mid-frame:
  - The current frame still shows old digits.
  - In the next frame, dec_d = 4, 3, 2, 1 for dig_sel = 0001, 0010, 0100, 1000.
  - Also pulse load on the frame-boundary cycle: the new value appears in the immediately following frame.
- lzb_en = 1, bcd_in = 16'h0050:
  - dec_bl = 0 in slots 3 and 2.
  - Slot 1: dec_d = 5, dec_bl = 1. Slot 0: dec_d = 0, dec_bl = 1.
  - With bcd_in = 16'h0000, only slot 0 is lit.
- Drop disp_en in mid-slot: next clock dig_sel = 0 and dec_bl = 0, held. Raise disp_en: the scan restarts at slot 0 with a guard cycle.
- Pulse lamp_test_req at idx = 2, cnt = 2:
  - Next clock busy = 1 and idx restarts at 0.
  - dec_lt = 0 for 16 clocks, then RUN resumes.
  - A second lamp_test_req during LAMP does not extend it.
- Assert rst_n low mid-RUN between clock edges: outputs take reset values without waiting for a clock edge, and the display register is cleared.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scan controller sharing one BCD-to-7-segment decoder across DIGITS positions.
// Handles lamp test, frame-synchronous updates, leading-zero and guard blanking.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_LAMP | lamp test: all segments on, scanning, busy = 1
// S_RUN  | normal scan of the display register
// S_OFF  | display disabled: digits dark, scan position held at 0
module seg7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 16,
  parameter int BLANK_CYC = 1,
  parameter int LT_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lzb_en,
  input  logic                  disp_en,
  input  logic                  lamp_test_req,
  output logic [3:0]            dec_d,
  output logic                  dec_le,
  output logic                  dec_bl,
  output logic                  dec_lt,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  busy
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(LT_FRAMES + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(LT_FRAMES - 1);

  localparam logic [1:0] S_LAMP = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]          state, state_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_adv;
  logic [IW-1:0]       idx, idx_n, idx_adv;
  logic [FW-1:0]       frm, frm_n;
  logic [4*DIGITS-1:0] hold, disp;
  logic                pending;
  logic                frame_end, transfer;

  logic [3:0]          digs [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic                zrun, guard;
  logic [DIGITS-1:0]   onehot, sel_n;
  logic [3:0]          d_n;
  logic                bl_n, lt_n, busy_n;

  always_comb begin
    frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);
    if (cnt == CNT_MAX) begin
      cnt_adv = '0;
      idx_adv = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt_adv = cnt + 1'b1;
      idx_adv = idx;
    end

    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    frm_n   = frm;
    case (state)
      S_LAMP: begin
        cnt_n = cnt_adv;
        idx_n = idx_adv;
        if (frame_end) begin
          if (frm == FRM_LAST) begin
            frm_n   = '0;
            state_n = disp_en ? S_RUN : S_OFF;
          end else begin
            frm_n = frm + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (lamp_test_req) begin
          state_n = S_LAMP;
          cnt_n   = '0;
          idx_n   = '0;
          frm_n   = '0;
        end else if (!disp_en) begin
          state_n = S_OFF;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt_adv;
          idx_n = idx_adv;
        end
      end
      default: begin
        cnt_n = '0;
        idx_n = '0;
        if (lamp_test_req) begin
          state_n = S_LAMP;
          frm_n   = '0;
        end else if (disp_en) begin
          state_n = S_RUN;
        end
      end
    endcase

    // New values only land between frames so a frame never mixes old and new digits.
    transfer = (frame_end && (state == S_LAMP || state == S_RUN)) ||
               (state == S_OFF && !lamp_test_req && disp_en);
  end

  always_comb begin
    zrun  = 1'b1;
    blank = '0;
    for (int i = 0; i < DIGITS; i++) digs[i] = disp[4*i +: 4];
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun     = zrun && (digs[i] == 4'd0);
      blank[i] = lzb_en && zrun && (i != 0);
    end

    guard       = (BLANK_CYC > 0) && (int'(cnt) < BLANK_CYC);
    onehot      = '0;
    onehot[idx] = 1'b1;

    sel_n  = '0;
    d_n    = 4'd0;
    bl_n   = 1'b0;
    lt_n   = 1'b1;
    busy_n = 1'b0;
    case (state)
      S_LAMP: begin
        sel_n  = guard ? '0 : onehot;
        bl_n   = !guard;
        lt_n   = 1'b0;
        busy_n = 1'b1;
      end
      S_RUN: begin
        sel_n = guard ? '0 : onehot;
        d_n   = digs[idx];
        bl_n  = !guard && !blank[idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LAMP;
      cnt     <= '0;
      idx     <= '0;
      frm     <= '0;
      hold    <= '0;
      disp    <= '0;
      pending <= 1'b0;
      dig_sel <= '0;
      dec_d   <= 4'd0;
      dec_le  <= 1'b0;
      dec_bl  <= 1'b0;
      dec_lt  <= 1'b1;
      busy    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      frm     <= frm_n;
      dig_sel <= sel_n;
      dec_d   <= d_n;
      dec_le  <= 1'b0;
      dec_bl  <= bl_n;
      dec_lt  <= lt_n;
      busy    <= busy_n;
      if (transfer) begin
        if (load) begin
          disp    <= bcd_in;
          hold    <= bcd_in;
          pending <= 1'b0;
        end else if (pending) begin
          disp    <= hold;
          pending <= 1'b0;
        end
      end else if (load) begin
        hold    <= bcd_in;
        pending <= 1'b1;
      end
    end
  end

endmodule
